// File: rtl/ntt_sched.sv
// ntt_sched: address and twiddle sequencer for a 2^LOG_N-point NTT/INTT
// butterfly datapath. One butterfly per cycle per stage, a drain gap of
// BT_LAT+1 cycles between stages, and write-back addresses delayed to
// line up with the butterfly pipeline.
module ntt_sched #(
  parameter int unsigned LOG_N  = 8,
  parameter int unsigned BT_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [LOG_N-1:0]           rd_addr0,
  output logic [LOG_N-1:0]           rd_addr1,
  output logic [LOG_N-1:0]           zeta_addr,
  output logic                       zeta_neg,
  output logic                       wr_en,
  output logic [LOG_N-1:0]           wr_addr0,
  output logic [LOG_N-1:0]           wr_addr1,
  output logic [$clog2(LOG_N)-1:0]   stage
);

  localparam int unsigned SW = $clog2(LOG_N);
  localparam int unsigned BW = LOG_N - 1;
  localparam int unsigned DW = $clog2(BT_LAT + 1) + 1;

  localparam logic [SW-1:0]    LAST_S     = SW'(LOG_N - 1);
  localparam logic [SW-1:0]    S_ONE      = SW'(1);
  localparam logic [BW-1:0]    LAST_B     = '1;
  localparam logic [BW-1:0]    B_ONE      = BW'(1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(BT_LAT);
  localparam logic [DW-1:0]    D_ONE      = DW'(1);
  localparam logic [LOG_N-1:0] W_ONE      = LOG_N'(1);
  localparam logic [LOG_N-1:0] W_ALL      = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_nxt_state;
  logic [BW-1:0]   r_b,     w_nxt_b;
  logic [SW-1:0]   r_s,     w_nxt_s;
  logic            r_mode,  w_nxt_mode;
  logic [DW-1:0]   r_dcnt,  w_nxt_dcnt;

  // Output-side combinational values, computed for the upcoming cycle
  logic            w_issue;
  logic            w_busy;
  logic            w_done;
  logic [SW-1:0]   w_lg;
  logic [LOG_N-1:0] w_bx, w_len, w_g, w_o, w_a0, w_a1, w_k;
  logic [LOG_N-1:0] w_rd0, w_rd1, w_zk;

  // Registered outputs
  logic            r_busy, r_done, r_rd_en, r_zeta_neg;
  logic [LOG_N-1:0] r_rd_addr0, r_rd_addr1, r_zeta_addr;
  logic [SW-1:0]   r_stage;

  // Write-back delay line: slot 0 holds last cycle's read, slot BT_LAT is the tail
  logic [BT_LAT:0]              r_dl_v;
  logic [BT_LAT:0][LOG_N-1:0]   r_dl_a0;
  logic [BT_LAT:0][LOG_N-1:0]   r_dl_a1;

  // FSM state and loop counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_b     <= '0;
      r_s     <= '0;
      r_mode  <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_b     <= w_nxt_b;
      r_s     <= w_nxt_s;
      r_mode  <= w_nxt_mode;
      r_dcnt  <= w_nxt_dcnt;
    end
  end

  // Next-state and counter update
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_b     = r_b;
    w_nxt_s     = r_s;
    w_nxt_mode  = r_mode;
    w_nxt_dcnt  = r_dcnt;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_state = S_ISSUE;
          w_nxt_mode  = mode;
          w_nxt_s     = '0;
          w_nxt_b     = '0;
        end
      end
      S_ISSUE: begin
        if (r_b == LAST_B) begin
          w_nxt_state = S_DRAIN;
          w_nxt_dcnt  = '0;
        end else begin
          w_nxt_b = r_b + B_ONE;
        end
      end
      S_DRAIN: begin
        if (r_dcnt == DRAIN_LAST) begin
          if (r_s == LAST_S) begin
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_state = S_ISSUE;
            w_nxt_s     = r_s + S_ONE;
            w_nxt_b     = '0;
          end
        end else begin
          w_nxt_dcnt = r_dcnt + D_ONE;
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output can be registered.
  // (N >> s) - 1 is computed as all-ones >> s to stay within LOG_N bits.
  always_comb begin
    w_issue = (w_nxt_state == S_ISSUE);
    w_busy  = (w_nxt_state == S_ISSUE) || (w_nxt_state == S_DRAIN);
    w_done  = (w_nxt_state == S_DONE);
    w_lg    = w_nxt_mode ? w_nxt_s : (LAST_S - w_nxt_s);
    w_bx    = {1'b0, w_nxt_b};
    w_len   = W_ONE << w_lg;
    w_g     = w_bx >> w_lg;
    w_o     = w_bx & (w_len - W_ONE);
    w_a0    = ((w_g << w_lg) << 1) | w_o;
    w_a1    = w_a0 | w_len;
    w_k     = w_nxt_mode ? ((W_ALL >> w_nxt_s) - w_g) : ((W_ONE << w_nxt_s) + w_g);
    w_rd0   = w_issue ? w_a0 : '0;
    w_rd1   = w_issue ? w_a1 : '0;
    w_zk    = w_issue ? w_k  : '0;
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr0  <= '0;
      r_rd_addr1  <= '0;
      r_zeta_addr <= '0;
      r_zeta_neg  <= 1'b0;
      r_stage     <= '0;
    end else begin
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_rd_en     <= w_issue;
      r_rd_addr0  <= w_rd0;
      r_rd_addr1  <= w_rd1;
      r_zeta_addr <= w_zk;
      r_zeta_neg  <= w_nxt_mode;
      r_stage     <= w_nxt_s;
    end
  end

  // Write-back delay line matching RAM read latency plus butterfly latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dl_v  <= '0;
      r_dl_a0 <= '0;
      r_dl_a1 <= '0;
    end else begin
      r_dl_v[0]  <= r_rd_en;
      r_dl_a0[0] <= r_rd_addr0;
      r_dl_a1[0] <= r_rd_addr1;
      for (int unsigned i = 1; i <= BT_LAT; i++) begin
        r_dl_v[i]  <= r_dl_v[i-1];
        r_dl_a0[i] <= r_dl_a0[i-1];
        r_dl_a1[i] <= r_dl_a1[i-1];
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign rd_addr0  = r_rd_addr0;
  assign rd_addr1  = r_rd_addr1;
  assign zeta_addr = r_zeta_addr;
  assign zeta_neg  = r_zeta_neg;
  assign stage     = r_stage;
  assign wr_en     = r_dl_v[BT_LAT];
  assign wr_addr0  = r_dl_a0[BT_LAT];
  assign wr_addr1  = r_dl_a1[BT_LAT];

endmodule

// File: tb/tb_ntt_sched.sv
// Testbench for ntt_sched: scoreboard of expected reads and write-backs for
// the BT_LAT=2 instance, plus BT_LAT=1/4 instances for the latency sweep.
module tb_ntt_sched;

  localparam int TOTAL2 = 1049;

  logic clk = 1'b0;
  logic reset, start, mode;

  logic       d2_busy, d2_done, d2_rd_en, d2_zeta_neg, d2_wr_en;
  logic [7:0] d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_wr_addr0, d2_wr_addr1;
  logic [2:0] d2_stage;
  logic       d1_busy, d1_done, d1_rd_en, d1_zeta_neg, d1_wr_en;
  logic [7:0] d1_rd_addr0, d1_rd_addr1, d1_zeta_addr, d1_wr_addr0, d1_wr_addr1;
  logic [2:0] d1_stage;
  logic       d4_busy, d4_done, d4_rd_en, d4_zeta_neg, d4_wr_en;
  logic [7:0] d4_rd_addr0, d4_rd_addr1, d4_zeta_addr, d4_wr_addr0, d4_wr_addr1;
  logic [2:0] d4_stage;

  ntt_sched #(.LOG_N(8), .BT_LAT(2)) u_d2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(d2_busy), .done(d2_done), .rd_en(d2_rd_en),
    .rd_addr0(d2_rd_addr0), .rd_addr1(d2_rd_addr1), .zeta_addr(d2_zeta_addr),
    .zeta_neg(d2_zeta_neg), .wr_en(d2_wr_en), .wr_addr0(d2_wr_addr0),
    .wr_addr1(d2_wr_addr1), .stage(d2_stage));

  ntt_sched #(.LOG_N(8), .BT_LAT(1)) u_d1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(d1_busy), .done(d1_done), .rd_en(d1_rd_en),
    .rd_addr0(d1_rd_addr0), .rd_addr1(d1_rd_addr1), .zeta_addr(d1_zeta_addr),
    .zeta_neg(d1_zeta_neg), .wr_en(d1_wr_en), .wr_addr0(d1_wr_addr0),
    .wr_addr1(d1_wr_addr1), .stage(d1_stage));

  ntt_sched #(.LOG_N(8), .BT_LAT(4)) u_d4 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(d4_busy), .done(d4_done), .rd_en(d4_rd_en),
    .rd_addr0(d4_rd_addr0), .rd_addr1(d4_rd_addr1), .zeta_addr(d4_zeta_addr),
    .zeta_neg(d4_zeta_neg), .wr_en(d4_wr_en), .wr_addr0(d4_wr_addr0),
    .wr_addr1(d4_wr_addr1), .stage(d4_stage));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] a0; logic [7:0] a1; logic [7:0] k; logic [2:0] s; } rd_t;
  typedef struct { logic [7:0] a0; logic [7:0] a1; int due; logic [2:0] s; } wr_t;

  rd_t exp_rd[$];
  wr_t exp_wr[$];
  rd_t er;
  wr_t ew;

  int checks = 0;
  int failures = 0;
  int t0 = 0;
  int rel;
  bit ref_idle = 1'b1;
  logic run_mode = 1'b0;
  logic exp_busy, exp_done;
  int hazard_viol = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int m_len, m_g, m_o, m_a0, m_k;

  // Scoreboard for the BT_LAT=2 instance, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      exp_rd.delete();
      exp_wr.delete();
      ref_idle = 1'b1;
    end else begin
      rel = cyc - t0;
      exp_busy = !ref_idle && rel >= 1 && rel <= TOTAL2 - 1;
      exp_done = !ref_idle && rel == TOTAL2;
      checks++;
      if (d2_busy !== exp_busy) begin
        failures++;
        $display("FAIL mon_busy cycle=%0d got=%b exp=%b", cyc, d2_busy, exp_busy);
      end
      checks++;
      if (d2_done !== exp_done) begin
        failures++;
        $display("FAIL mon_done cycle=%0d got=%b exp=%b", cyc, d2_done, exp_done);
      end
      if (d2_rd_en === 1'b1) begin
        checks++;
        if (exp_rd.size() == 0) begin
          failures++;
          $display("FAIL mon_rd_unexpected cycle=%0d got=1 exp=0", cyc);
        end else begin
          er = exp_rd.pop_front();
          if ({d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_stage, d2_zeta_neg} !==
              {er.a0, er.a1, er.k, er.s, run_mode}) begin
            failures++;
            $display("FAIL mon_rd cycle=%0d got a0=%0d a1=%0d k=%0d s=%0d neg=%b exp a0=%0d a1=%0d k=%0d s=%0d neg=%b",
                     cyc, d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_stage, d2_zeta_neg,
                     er.a0, er.a1, er.k, er.s, run_mode);
          end
          foreach (exp_wr[i]) begin
            if (exp_wr[i].s != er.s &&
                (exp_wr[i].a0 == er.a0 || exp_wr[i].a0 == er.a1 ||
                 exp_wr[i].a1 == er.a0 || exp_wr[i].a1 == er.a1))
              hazard_viol++;
          end
          exp_wr.push_back('{er.a0, er.a1, cyc + 3, er.s});
          rd_cnt++;
        end
      end
      if (d2_wr_en === 1'b1) begin
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL mon_wr_unexpected cycle=%0d got=1 exp=0", cyc);
        end else begin
          ew = exp_wr.pop_front();
          if ({d2_wr_addr0, d2_wr_addr1} !== {ew.a0, ew.a1} || ew.due != cyc) begin
            failures++;
            $display("FAIL mon_wr cycle=%0d got a0=%0d a1=%0d exp a0=%0d a1=%0d due=%0d",
                     cyc, d2_wr_addr0, d2_wr_addr1, ew.a0, ew.a1, ew.due);
          end
          wr_cnt++;
        end
      end else if (exp_wr.size() > 0 && exp_wr[0].due == cyc) begin
        checks++;
        failures++;
        $display("FAIL mon_wr_missing cycle=%0d got=0 exp=1", cyc);
        void'(exp_wr.pop_front());
      end
      if (ref_idle && start === 1'b1) begin
        t0 = cyc;
        ref_idle = 1'b0;
        run_mode = mode;
        for (int s = 0; s < 8; s++) begin
          for (int b = 0; b < 128; b++) begin
            m_len = mode ? (1 << s) : (128 >> s);
            m_g   = b / m_len;
            m_o   = b % m_len;
            m_a0  = 2 * m_g * m_len + m_o;
            m_k   = mode ? ((256 >> s) - 1 - m_g) : ((1 << s) + m_g);
            er.a0 = 8'(m_a0);
            er.a1 = 8'(m_a0 + m_len);
            er.k  = 8'(m_k);
            er.s  = 3'(s);
            exp_rd.push_back(er);
          end
        end
      end else if (!ref_idle && rel == TOTAL2) begin
        ref_idle = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    step(); step();
    checks++;
    if ({d2_busy, d2_done, d2_rd_en, d2_wr_en, d2_zeta_neg} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {d2_busy, d2_done, d2_rd_en, d2_wr_en, d2_zeta_neg});
    end
    checks++;
    if ({d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_wr_addr0, d2_wr_addr1} !== 40'h0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=0", {d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_wr_addr0, d2_wr_addr1});
    end
    checks++;
    if (d2_stage !== 3'd0) begin
      failures++;
      $display("FAIL reset_stage got=%0d exp=0", d2_stage);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({d2_busy, d2_rd_en, d2_wr_en} !== 3'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=000", {d2_busy, d2_rd_en, d2_wr_en});
    end
  endtask

  task automatic test_forward();
    int t_s, n;
    hazard_viol = 0; rd_cnt = 0; wr_cnt = 0;
    mode = 1'b0; start = 1'b1; t_s = cyc;
    step();
    start = 1'b0;
    checks++;
    if ({d2_rd_en, d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_stage} !== {1'b1, 8'd0, 8'd128, 8'd1, 3'd0}) begin
      failures++;
      $display("FAIL fwd_first got a0=%0d a1=%0d k=%0d s=%0d exp a0=0 a1=128 k=1 s=0",
               d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_stage);
    end
    while (cyc - t_s < 1045) step();
    checks++;
    if ({d2_rd_en, d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_stage} !== {1'b1, 8'd254, 8'd255, 8'd255, 3'd7}) begin
      failures++;
      $display("FAIL fwd_last got a0=%0d a1=%0d k=%0d s=%0d exp a0=254 a1=255 k=255 s=7",
               d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_stage);
    end
    n = 0;
    while (d2_done !== 1'b1 && n < 1200) begin step(); n++; end
    checks++;
    if (cyc - t_s != TOTAL2) begin
      failures++;
      $display("FAIL fwd_done_cycle got=%0d exp=%0d", cyc - t_s, TOTAL2);
    end
    step();
    checks++;
    if (d2_done !== 1'b0) begin
      failures++;
      $display("FAIL fwd_done_pulse got=%b exp=0", d2_done);
    end
    checks++;
    if (hazard_viol != 0 || rd_cnt != 1024 || wr_cnt != 1024 || exp_rd.size() != 0) begin
      failures++;
      $display("FAIL fwd_trace got haz=%0d rd=%0d wr=%0d left=%0d exp haz=0 rd=1024 wr=1024 left=0",
               hazard_viol, rd_cnt, wr_cnt, exp_rd.size());
    end
  endtask

  task automatic test_inverse();
    int t_s, n;
    hazard_viol = 0; rd_cnt = 0; wr_cnt = 0;
    mode = 1'b1; start = 1'b1; t_s = cyc;
    step();
    start = 1'b0;
    checks++;
    if ({d2_rd_en, d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_zeta_neg} !== {1'b1, 8'd0, 8'd1, 8'd255, 1'b1}) begin
      failures++;
      $display("FAIL inv_first got a0=%0d a1=%0d k=%0d neg=%b exp a0=0 a1=1 k=255 neg=1",
               d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_zeta_neg);
    end
    while (cyc - t_s < 918) step();
    checks++;
    if ({d2_rd_en, d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_stage} !== {1'b1, 8'd0, 8'd128, 8'd1, 3'd7}) begin
      failures++;
      $display("FAIL inv_s7 got a0=%0d a1=%0d k=%0d s=%0d exp a0=0 a1=128 k=1 s=7",
               d2_rd_addr0, d2_rd_addr1, d2_zeta_addr, d2_stage);
    end
    n = 0;
    while (d2_done !== 1'b1 && n < 1200) begin step(); n++; end
    checks++;
    if (cyc - t_s != TOTAL2 || d2_zeta_neg !== 1'b1) begin
      failures++;
      $display("FAIL inv_done got cyc=%0d neg=%b exp cyc=%0d neg=1", cyc - t_s, d2_zeta_neg, TOTAL2);
    end
    step();
    checks++;
    if (hazard_viol != 0 || rd_cnt != 1024 || wr_cnt != 1024) begin
      failures++;
      $display("FAIL inv_trace got haz=%0d rd=%0d wr=%0d exp haz=0 rd=1024 wr=1024",
               hazard_viol, rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_start_held();
    int t_s, n;
    mode = 1'b0; start = 1'b1; t_s = cyc;
    step();
    while (cyc - t_s < 300) step();
    mode = 1'b1;
    n = 0;
    while (d2_done !== 1'b1 && n < 1200) begin step(); n++; end
    checks++;
    if (cyc - t_s != TOTAL2) begin
      failures++;
      $display("FAIL held_done_cycle got=%0d exp=%0d", cyc - t_s, TOTAL2);
    end
    step();
    checks++;
    if ({d2_busy, d2_rd_en} !== 2'b00) begin
      failures++;
      $display("FAIL held_idle got=%b exp=00", {d2_busy, d2_rd_en});
    end
    step();
    checks++;
    if ({d2_rd_en, d2_zeta_neg, d2_rd_addr1, d2_stage} !== {1'b1, 1'b1, 8'd1, 3'd0}) begin
      failures++;
      $display("FAIL held_restart got rd=%b neg=%b a1=%0d s=%0d exp rd=1 neg=1 a1=1 s=0",
               d2_rd_en, d2_zeta_neg, d2_rd_addr1, d2_stage);
    end
    start = 1'b0;
    n = 0;
    while (d2_done !== 1'b1 && n < 1200) begin step(); n++; end
    checks++;
    if (cyc - (t_s + 1050) != TOTAL2) begin
      failures++;
      $display("FAIL held_second_done got=%0d exp=%0d", cyc - (t_s + 1050), TOTAL2);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int t_s, n;
    mode = 1'b0; start = 1'b1; t_s = cyc;
    step();
    start = 1'b0;
    while (cyc - t_s < 500) step();
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({d2_busy, d2_rd_en, d2_wr_en, d2_done} !== 4'b0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b exp=0000", {d2_busy, d2_rd_en, d2_wr_en, d2_done});
    end
    step();
    reset = 1'b0;
    step();
    mode = 1'b0; start = 1'b1; t_s = cyc;
    step();
    start = 1'b0;
    checks++;
    if ({d2_rd_en, d2_stage, d2_rd_addr1} !== {1'b1, 3'd0, 8'd128}) begin
      failures++;
      $display("FAIL rstmid_restart got rd=%b s=%0d a1=%0d exp rd=1 s=0 a1=128", d2_rd_en, d2_stage, d2_rd_addr1);
    end
    n = 0;
    while (d2_done !== 1'b1 && n < 1200) begin step(); n++; end
    checks++;
    if (cyc - t_s != TOTAL2) begin
      failures++;
      $display("FAIL rstmid_done got=%0d exp=%0d", cyc - t_s, TOTAL2);
    end
    step();
  endtask

  task automatic test_sweep();
    logic [16:0] h1 [0:1199];
    logic [16:0] h4 [0:1199];
    int f1w, f4w, f1s, f4s, dn1, dn4, c1, c4, w1, w4;
    f1w = 0; f4w = 0; f1s = 0; f4s = 0; dn1 = 0; dn4 = 0; c1 = 0; c4 = 0; w1 = 0; w4 = 0;
    for (int i = 0; i < 1200; i++) begin h1[i] = '0; h4[i] = '0; end
    reset = 1'b1; step(); reset = 1'b0; step();
    mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 1; r <= 1100; r++) begin
      h1[r] = {d1_rd_en, d1_rd_addr0, d1_rd_addr1};
      h4[r] = {d4_rd_en, d4_rd_addr0, d4_rd_addr1};
      if (d1_wr_en === 1'b1) begin
        if (f1w == 0) f1w = r;
        w1++;
        checks++;
        if (r < 3 || h1[r-2] !== {1'b1, d1_wr_addr0, d1_wr_addr1}) begin
          failures++;
          $display("FAIL sweep1_wr rel=%0d got=%h exp=%h", r, {1'b1, d1_wr_addr0, d1_wr_addr1}, (r < 3) ? 17'h0 : h1[r-2]);
        end
      end
      if (d4_wr_en === 1'b1) begin
        if (f4w == 0) f4w = r;
        w4++;
        checks++;
        if (r < 6 || h4[r-5] !== {1'b1, d4_wr_addr0, d4_wr_addr1}) begin
          failures++;
          $display("FAIL sweep4_wr rel=%0d got=%h exp=%h", r, {1'b1, d4_wr_addr0, d4_wr_addr1}, (r < 6) ? 17'h0 : h4[r-5]);
        end
      end
      if (d1_rd_en === 1'b1 && d1_stage == 3'd1 && f1s == 0) f1s = r;
      if (d4_rd_en === 1'b1 && d4_stage == 3'd1 && f4s == 0) f4s = r;
      if (d1_done === 1'b1) begin dn1 = r; c1++; end
      if (d4_done === 1'b1) begin dn4 = r; c4++; end
      step();
    end
    checks++;
    if (f1w != 3 || f4w != 6) begin
      failures++;
      $display("FAIL sweep_first_wr got bt1=%0d bt4=%0d exp bt1=3 bt4=6", f1w, f4w);
    end
    checks++;
    if (f1s != 131 || f4s != 134) begin
      failures++;
      $display("FAIL sweep_drain got bt1=%0d bt4=%0d exp bt1=131 bt4=134", f1s, f4s);
    end
    checks++;
    if (dn1 != 1041 || dn4 != 1065 || c1 != 1 || c4 != 1) begin
      failures++;
      $display("FAIL sweep_done got bt1=%0d/%0d bt4=%0d/%0d exp bt1=1041/1 bt4=1065/1", dn1, c1, dn4, c4);
    end
    checks++;
    if (w1 != 1024 || w4 != 1024) begin
      failures++;
      $display("FAIL sweep_wr_count got bt1=%0d bt4=%0d exp 1024", w1, w4);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    test_reset();
    test_forward();
    test_inverse();
    test_start_held();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
